uart_multi_byte_rx: RTL and testbench

Serial UART receiver with an integrated fixed-length packet parser. It deserialises 8N1 bytes from `uart_rxd` and frames them into 8-byte packets of the form `0x55`, P0..P4, `0x0D`, `0x0A`. It then unpacks the 5 payload bytes into three parameter registers (`dataA`, `dataB`, `dataC`). It sits between the board UART pin and the DDS control registers.

---
 rtl/uart_multi_byte_rx.sv | 198 +++++++++++++++++++
 tb/tb_uart_multi_byte_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_multi_byte_rx.sv
// 8N1 UART byte receiver with a fixed 8-byte packet parser.
// Frames 55 P0..P4 0D 0A and unpacks the payload into dataA/B/C.
module uart_multi_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 230400
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rxd,
  output logic [7:0]  uart_data,
  output logic        uart_done,
  output logic        uart_get,
  output logic [7:0]  pack_cnt,
  output logic        pack_ing,
  output logic        pack_done,
  output logic [7:0]  pack_num,
  output logic        recv_done,
  output logic [7:0]  dataA,
  output logic [15:0] dataB,
  output logic [15:0] dataC
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BPS_MAX = 16'(BPS_CNT - 1);
  localparam logic [15:0] BPS_MID = 16'(BPS_CNT / 2);

  typedef enum logic {IDLE, COLLECT} state_t;

  // receiver state
  logic [2:0]  rxd_q;
  logic        get_q, get_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        fall;

  // parser state
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ing_q, ing_d;
  logic        pdone_q, pdone_d;
  logic        rdone_q, rdone_d;
  logic [7:0]  num_q, num_d;
  logic [7:0]  buf_q [0:6];
  logic [7:0]  buf_d [0:6];
  logic [7:0]  a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] c_q, c_d;

  // rxd[1] is the synchronised line, rxd[2] its previous value
  assign fall = rxd_q[2] & ~rxd_q[1];

  // synchroniser and edge-detect history, idle-high preset
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) rxd_q <= 3'b111;
    else           rxd_q <= {rxd_q[1:0], uart_rxd};
  end

  // byte receiver: bit/clock counters, mid-bit sampling, LSB first
  always_comb begin
    get_d     = get_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    if (!get_q) begin
      if (fall) begin
        get_d     = 1'b1;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    end else begin
      if (clk_cnt_q == BPS_MID && bit_cnt_q != 4'd0)
        shift_d = {rxd_q[1], shift_q[7:1]};
      if (clk_cnt_q == BPS_MAX) begin
        clk_cnt_d = '0;
        if (bit_cnt_q == 4'd8) begin
          // stop bit is not checked: return to idle right away
          get_d     = 1'b0;
          bit_cnt_d = '0;
          done_d    = 1'b1;
          data_d    = shift_q;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end else begin
        clk_cnt_d = clk_cnt_q + 16'd1;
      end
    end
  end

  // receiver registers
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      get_q     <= 1'b0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      get_q     <= get_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  // packet parser: next state, buffer fill and tail check
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ing_d   = ing_q;
    pdone_d = 1'b0;
    rdone_d = 1'b0;
    num_d   = num_q;
    buf_d   = buf_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    if (done_q) begin
      unique case (state_q)
        IDLE: begin
          if (data_q == 8'h55) begin
            buf_d[0] = data_q;
            cnt_d    = 8'd1;
            ing_d    = 1'b1;
            state_d  = COLLECT;
          end
        end
        COLLECT: begin
          if (cnt_q == 8'd7) begin
            pdone_d = 1'b1;
            cnt_d   = '0;
            ing_d   = 1'b0;
            state_d = IDLE;
            if (buf_q[6] == 8'h0D && data_q == 8'h0A) begin
              a_d     = buf_q[1];
              b_d     = {buf_q[2], buf_q[3]};
              c_d     = {buf_q[4], buf_q[5]};
              rdone_d = 1'b1;
              num_d   = num_q + 8'd1;
            end
          end else begin
            buf_d[cnt_q[2:0]] = data_q;
            cnt_d             = cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // parser registers
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ing_q   <= 1'b0;
      pdone_q <= 1'b0;
      rdone_q <= 1'b0;
      num_q   <= '0;
      for (int i = 0; i < 7; i++) buf_q[i] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ing_q   <= ing_d;
      pdone_q <= pdone_d;
      rdone_q <= rdone_d;
      num_q   <= num_d;
      buf_q   <= buf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  assign uart_data = data_q;
  assign uart_done = done_q;
  assign uart_get  = get_q;
  assign pack_cnt  = cnt_q;
  assign pack_ing  = ing_q;
  assign pack_done = pdone_q;
  assign pack_num  = num_q;
  assign recv_done = rdone_q;
  assign dataA     = a_q;
  assign dataB     = b_q;
  assign dataC     = c_q;

endmodule

// File: tb/tb_uart_multi_byte_rx.sv
// Directed bench for uart_multi_byte_rx.
// Byte and packet scoreboards are checked as the DUT reports them.
module tb_uart_multi_byte_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int UART_BPS = 1_000_000;
  localparam int BPS      = CLK_FREQ / UART_BPS;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        uart_rxd;
  logic [7:0]  uart_data;
  logic        uart_done;
  logic        uart_get;
  logic [7:0]  pack_cnt;
  logic        pack_ing;
  logic        pack_done;
  logic [7:0]  pack_num;
  logic        recv_done;
  logic [7:0]  dataA;
  logic [15:0] dataB;
  logic [15:0] dataC;

  uart_multi_byte_rx #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .uart_rxd (uart_rxd),
    .uart_data(uart_data),
    .uart_done(uart_done),
    .uart_get (uart_get),
    .pack_cnt (pack_cnt),
    .pack_ing (pack_ing),
    .pack_done(pack_done),
    .pack_num (pack_num),
    .recv_done(recv_done),
    .dataA    (dataA),
    .dataB    (dataB),
    .dataC    (dataC)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    logic        r;
    logic [7:0]  a;
    logic [15:0] b;
    logic [15:0] c;
    logic [7:0]  n;
  } pk_t;

  logic [7:0] byte_q [$];
  pk_t        pk_q [$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;
  int pdone_cnt = 0;
  int exp_pdone = 0;

  logic [7:0]  ea = '0;
  logic [15:0] eb = '0;
  logic [15:0] ec = '0;
  logic [7:0]  en = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // scoreboard side: compare each reported byte and packet
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      if (uart_done) begin
        done_cnt++;
        if (byte_q.size() == 0) check("byte_unexpected", 1, 0);
        else check("byte_data", {24'd0, uart_data}, {24'd0, byte_q.pop_front()});
      end
      if (pack_done) begin
        pk_t e;
        pdone_cnt++;
        if (pk_q.size() == 0) check("pack_unexpected", 1, 0);
        else begin
          e = pk_q.pop_front();
          check("recv_done", {31'd0, recv_done}, {31'd0, e.r});
          check("dataA", {24'd0, dataA}, {24'd0, e.a});
          check("dataB", {16'd0, dataB}, {16'd0, e.b});
          check("dataC", {16'd0, dataC}, {16'd0, e.c});
          check("pack_num", {24'd0, pack_num}, {24'd0, e.n});
        end
      end else if (recv_done) begin
        check("recv_without_pack", 1, 0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic [7:0] ecnt,
                           input logic eing);
    int d0;
    byte_q.push_back(b);
    d0 = done_cnt;
    uart_rxd = 1'b0;
    cyc(BPS);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      cyc(BPS);
    end
    uart_rxd = 1'b1;
    cyc(BPS / 3);
    check("done_by_third_stop", done_cnt, d0 + 1);
    check("uart_data_stable", {24'd0, uart_data}, {24'd0, b});
    check("pack_cnt", {24'd0, pack_cnt}, {24'd0, ecnt});
    check("pack_ing", {31'd0, pack_ing}, {31'd0, eing});
    cyc(BPS - BPS / 3);
  endtask

  task automatic send_pkt(input logic [63:0] p);
    pk_t e;
    logic good;
    logic [7:0] s [8];
    for (int i = 0; i < 8; i++) s[i] = p[63 - 8 * i -: 8];
    good = (s[6] == 8'h0D) && (s[7] == 8'h0A);
    for (int i = 0; i < 7; i++) send_byte(s[i], 8'(i + 1), 1'b1);
    if (good) begin
      ea = s[1];
      eb = {s[2], s[3]};
      ec = {s[4], s[5]};
      en = en + 8'd1;
    end
    e.r = good;
    e.a = ea;
    e.b = eb;
    e.c = ec;
    e.n = en;
    pk_q.push_back(e);
    exp_pdone++;
    send_byte(s[7], 8'd0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, {24'd0, uart_data}, 0);
    check({tag, "_get"}, {31'd0, uart_get}, 0);
    check({tag, "_cnt"}, {24'd0, pack_cnt}, 0);
    check({tag, "_ing"}, {31'd0, pack_ing}, 0);
    check({tag, "_num"}, {24'd0, pack_num}, 0);
    check({tag, "_dataA"}, {24'd0, dataA}, 0);
    check({tag, "_dataB"}, {16'd0, dataB}, 0);
    check({tag, "_dataC"}, {16'd0, dataC}, 0);
    check({tag, "_pulses"},
          {29'd0, uart_done, pack_done, recv_done}, 0);
  endtask

  initial begin
    sys_rst_n = 1'b1;
    uart_rxd  = 1'bx;
    cyc(5);
    uart_rxd = 1'b1;
    cyc(2);
    sys_rst_n = 1'b0;
    cyc(3);
    check_all_zero("reset");

    // first byte alone, then the rest of packet 1
    send_byte(8'h55, 8'd1, 1'b1);
    for (int i = 1; i < 7; i++) begin
      logic [7:0] t [8];
      t = '{8'h55, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h0D, 8'h0A};
      send_byte(t[i], 8'(i + 1), 1'b1);
    end
    ea = 8'h12;
    eb = 16'h1314;
    ec = 16'h1516;
    en = 8'd1;
    pk_q.push_back('{1'b1, 8'h12, 16'h1314, 16'h1516, 8'd1});
    exp_pdone++;
    send_byte(8'h0A, 8'd0, 1'b0);
    check("pkt1_dataA", {24'd0, dataA}, 32'h12);

    // back-to-back second packet
    send_pkt(64'h55_32_33_34_35_36_0D_0A);
    check("pkt2_dataB", {16'd0, dataB}, 32'h3334);
    check("pkt2_num", {24'd0, pack_num}, 2);

    // bad tail: pack_done without recv_done, registers hold
    send_pkt(64'h55_01_02_03_04_05_0D_0B);
    check("bad_dataC", {16'd0, dataC}, 32'h3536);

    // leading garbage before a valid packet
    send_byte(8'hAA, 8'd0, 1'b0);
    send_byte(8'h12, 8'd0, 1'b0);
    send_pkt(64'h55_0D_55_0A_77_88_0D_0A);

    // reset in the middle of byte 4
    send_byte(8'h55, 8'd1, 1'b1);
    send_byte(8'h41, 8'd2, 1'b1);
    send_byte(8'h42, 8'd3, 1'b1);
    uart_rxd = 1'b0;
    cyc(BPS);
    uart_rxd = 1'b1;
    cyc(BPS);
    uart_rxd = 1'b0;
    cyc(BPS);
    sys_rst_n = 1'b1;
    cyc(4);
    uart_rxd = 1'b1;
    cyc(4);
    sys_rst_n = 1'b0;
    cyc(2);
    check_all_zero("midreset");
    ea = '0;
    eb = '0;
    ec = '0;
    en = '0;
    cyc(2 * BPS);
    send_pkt(64'h55_A1_B2_C3_D4_E5_0D_0A);
    check("post_reset_num", {24'd0, pack_num}, 1);

    cyc(10);
    check("byte_queue_empty", byte_q.size(), 0);
    check("pack_queue_empty", pk_q.size(), 0);
    check("pack_done_count", pdone_cnt, exp_pdone);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
